id_repeat_sequencer: RTL and testbench

ID_REPEAT_SEQUENCER -- requirements
Module: id_repeat_sequencer

---
 rtl/id_repeat_sequencer.sv | 134 +++++++++++++
 tb/tb_id_repeat_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_repeat_sequencer.sv
// ID-stage repeat sequencer: a trigger instruction launches N repeat slots,
// each carrying its own destination register, slot index and remaining count.
module id_repeat_sequencer #(
   parameter int          DATA_W     = 32,
   parameter int          CNT_W      = 8,
   parameter int          REG_AW     = 4,
   parameter logic [3:0]  REP_OPCODE = 4'b0011,
   parameter int          AUTO_INC   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [3:0]        opcode,
   input  logic              hazard,
   input  logic              flush,
   input  logic [DATA_W-1:0] count_val,
   input  logic [REG_AW-1:0] dest_in,
   output logic              rep_active,
   output logic [REG_AW-1:0] rep_dest,
   output logic [CNT_W-1:0]  rep_remaining,
   output logic [CNT_W-1:0]  rep_index,
   output logic              rep_done,
   output logic              rep_sat
);

   localparam int CMP_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   logic [REG_AW-1:0]   r_dest;
   logic [CNT_W-1:0]    r_rem;
   logic [CNT_W-1:0]    r_idx;
   logic                r_done;
   logic                r_sat;

   state_t              w_state_next;
   logic [REG_AW-1:0]   w_dest_next;
   logic [CNT_W-1:0]    w_rem_next;
   logic [CNT_W-1:0]    w_idx_next;
   logic                w_done_next;
   logic                w_sat_next;

   logic                w_trigger;
   logic [CMP_W-1:0]    w_cnt_ext;
   logic [CMP_W-1:0]    w_max_ext;
   logic                w_over;
   logic [CNT_W-1:0]    w_clipped;
   logic [REG_AW-1:0]   w_step_dest;

   // Flush and hazard are resolved in the next-state priority, so the
   // trigger term only needs the decode qualification.
   assign w_trigger   = instr_valid && (opcode == REP_OPCODE);
   assign w_cnt_ext   = CMP_W'(count_val);
   assign w_max_ext   = CMP_W'({CNT_W{1'b1}});
   assign w_over      = (w_cnt_ext > w_max_ext);
   assign w_clipped   = w_over ? {CNT_W{1'b1}} : w_cnt_ext[CNT_W-1:0];
   assign w_step_dest = (AUTO_INC != 0) ? (r_dest + REG_AW'(1)) : r_dest;

   always_comb begin
      w_state_next = r_state;
      w_dest_next  = r_dest;
      w_rem_next   = r_rem;
      w_idx_next   = r_idx;
      w_done_next  = 1'b0;
      w_sat_next   = r_sat;
      if (flush) begin
         w_state_next = S_IDLE;
         w_dest_next  = '0;
         w_rem_next   = '0;
         w_idx_next   = '0;
      end else if (!hazard) begin
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  if (w_cnt_ext == '0) begin
                     w_done_next = 1'b1;
                     w_sat_next  = 1'b0;
                  end else begin
                     w_state_next = S_RUN;
                     w_dest_next  = dest_in;
                     w_rem_next   = w_clipped;
                     w_idx_next   = '0;
                     w_sat_next   = w_over;
                  end
               end
            end
            S_RUN: begin
               // The destination keeps stepping on the final edge as well.
               w_dest_next = w_step_dest;
               if (r_rem == CNT_W'(1)) begin
                  w_state_next = S_IDLE;
                  w_rem_next   = '0;
                  w_idx_next   = '0;
                  w_done_next  = 1'b1;
               end else begin
                  w_rem_next = r_rem - CNT_W'(1);
                  w_idx_next = r_idx + CNT_W'(1);
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_dest  <= '0;
         r_rem   <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_dest  <= w_dest_next;
         r_rem   <= w_rem_next;
         r_idx   <= w_idx_next;
         r_done  <= w_done_next;
         r_sat   <= w_sat_next;
      end
   end

   assign rep_active    = (r_state == S_RUN);
   assign rep_dest      = r_dest;
   assign rep_remaining = r_rem;
   assign rep_index     = r_idx;
   assign rep_done      = r_done;
   assign rep_sat       = r_sat;

endmodule

// File: tb/tb_id_repeat_sequencer.sv
// Randomized bench for id_repeat_sequencer: a slot-queue reference model
// predicts every output each cycle, plus directed scenarios.
module tb_id_repeat_sequencer;

   localparam logic [3:0] REP = 4'b0011;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [3:0]  opcode;
   logic        hazard;
   logic        flush;
   logic [31:0] count_val;
   logic [3:0]  dest_in;
   logic        rep_active;
   logic [3:0]  rep_dest;
   logic [7:0]  rep_remaining;
   logic [7:0]  rep_index;
   logic        rep_done;
   logic        rep_sat;

   id_repeat_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .instr_valid   (instr_valid),
      .opcode        (opcode),
      .hazard        (hazard),
      .flush         (flush),
      .count_val     (count_val),
      .dest_in       (dest_in),
      .rep_active    (rep_active),
      .rep_dest      (rep_dest),
      .rep_remaining (rep_remaining),
      .rep_index     (rep_index),
      .rep_done      (rep_done),
      .rep_sat       (rep_sat)
   );

   always #5 clk = ~clk;

   // Reference model: the pending repeat slots as a queue; the head is the
   // slot currently presented by the DUT.
   typedef struct {
      logic [3:0] dest;
      logic [7:0] rem;
      logic [7:0] idx;
   } slot_t;

   slot_t      q[$];
   logic       m_done;
   logic       m_sat;
   logic [3:0] m_idle_dest;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_done      = 1'b0;
      m_sat       = 1'b0;
      m_idle_dest = 4'd0;
   endtask

   task automatic model_edge();
      slot_t last;
      int    n;
      m_done = 1'b0;
      if (flush) begin
         q.delete();
         m_idle_dest = 4'd0;
      end else if (!hazard) begin
         if (q.size() != 0) begin
            last = q.pop_front();
            if (q.size() == 0) begin
               m_done      = 1'b1;
               m_idle_dest = last.dest + 4'd1;
            end
         end else if (instr_valid && opcode == REP) begin
            if (count_val == 32'd0) begin
               m_done = 1'b1;
               m_sat  = 1'b0;
            end else begin
               n     = (count_val > 32'd255) ? 255 : int'(count_val);
               m_sat = (count_val > 32'd255);
               for (int k = 0; k < n; k++) begin
                  slot_t s;
                  s.dest = dest_in + 4'(k);
                  s.rem  = 8'(n - k);
                  s.idx  = 8'(k);
                  q.push_back(s);
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      logic       e_act;
      logic [3:0] e_dest;
      logic [7:0] e_rem;
      logic [7:0] e_idx;
      e_act  = (q.size() != 0);
      e_dest = e_act ? q[0].dest : m_idle_dest;
      e_rem  = e_act ? q[0].rem  : 8'd0;
      e_idx  = e_act ? q[0].idx  : 8'd0;
      chk("active",    32'(rep_active),    32'(e_act));
      chk("dest",      32'(rep_dest),      32'(e_dest));
      chk("remaining", 32'(rep_remaining), 32'(e_rem));
      chk("index",     32'(rep_index),     32'(e_idx));
      chk("done",      32'(rep_done),      32'(m_done));
      chk("sat",       32'(rep_sat),       32'(m_sat));
      $display("t=%0t iv=%0b op=%0h hz=%0b fl=%0b cv=%0d d=%0d -> act=%0b dest=%0d rem=%0d idx=%0d done=%0b sat=%0b",
               $time, instr_valid, opcode, hazard, flush, count_val, dest_in,
               rep_active, rep_dest, rep_remaining, rep_index, rep_done, rep_sat);
   endtask

   // Drive inputs at the falling edge, model at the rising edge, check at the next falling edge.
   task automatic cycle(input logic iv, input logic [3:0] op, input logic hz, input logic fl,
                        input logic [31:0] cv, input logic [3:0] d);
      instr_valid = iv;
      opcode      = op;
      hazard      = hz;
      flush       = fl;
      count_val   = cv;
      dest_in     = d;
      @(posedge clk);
      if (!rst) model_reset();
      else model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 32'd0, 4'd0);
   endtask

   task automatic trig(input logic [31:0] cv, input logic [3:0] d);
      cycle(1'b1, REP, 1'b0, 1'b0, cv, d);
   endtask

   initial begin
      rst         = 1'b0;
      instr_valid = 1'b0;
      opcode      = 4'h0;
      hazard      = 1'b0;
      flush       = 1'b0;
      count_val   = 32'd0;
      dest_in     = 4'd0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b1;

      // Basic run straight out of reset: first edge accepts the trigger.
      trig(32'd3, 4'd5);
      chk("basic_rem0", 32'(rep_remaining), 32'd3);
      for (int i = 1; i < 3; i++) begin
         idle(1);
         chk("basic_dest", 32'(rep_dest), 32'(5 + i));
         chk("basic_idx",  32'(rep_index), 32'(i));
      end
      idle(1);
      chk("basic_done", 32'(rep_done), 32'd1);
      idle(1);
      chk("basic_done_pulse", 32'(rep_done), 32'd0);

      // Stall mid-run.
      trig(32'd2, 4'd9);
      cycle(1'b0, 4'h0, 1'b1, 1'b0, 32'd0, 4'd0);
      cycle(1'b0, 4'h0, 1'b1, 1'b0, 32'd0, 4'd0);
      chk("stall_frozen", 32'(rep_remaining), 32'd2);
      idle(3);

      // Flush together with hazard in the second RUN cycle.
      trig(32'd4, 4'd2);
      idle(1);
      cycle(1'b0, 4'h0, 1'b1, 1'b1, 32'd0, 4'd0);
      chk("flush_active", 32'(rep_active), 32'd0);
      chk("flush_nodone", 32'(rep_done), 32'd0);
      idle(2);

      // Zero count: no RUN, done pulse only.
      trig(32'd0, 4'd7);
      chk("zero_done",   32'(rep_done), 32'd1);
      chk("zero_active", 32'(rep_active), 32'd0);
      idle(1);

      // Saturation and destination wrap.
      trig(32'd300, 4'd15);
      chk("sat_rem", 32'(rep_remaining), 32'd255);
      chk("sat_flag", 32'(rep_sat), 32'd1);
      idle(1);
      chk("wrap_dest", 32'(rep_dest), 32'd0);
      idle(256);

      // Nesting attempt is ignored.
      trig(32'd5, 4'd1);
      trig(32'd9, 4'd8);
      trig(32'd9, 4'd8);
      chk("nest_rem", 32'(rep_remaining), 32'd3);
      idle(4);

      // Asynchronous reset mid-run, no clock edge involved.
      trig(32'd6, 4'd3);
      idle(1);
      #2 rst = 1'b0;
      #1;
      chk("arst_active", 32'(rep_active), 32'd0);
      chk("arst_rem",    32'(rep_remaining), 32'd0);
      chk("arst_dest",   32'(rep_dest), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      trig(32'd2, 4'd4);
      idle(3);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int          r;
         logic [31:0] cv;
         r = int'($urandom_range(0, 19));
         if (r == 0)      cv = $urandom;
         else if (r < 3)  cv = 32'd0;
         else             cv = $urandom_range(1, 6);
         cycle(($urandom_range(0, 3) != 0),
               ($urandom_range(0, 2) != 0) ? REP : 4'($urandom),
               ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 19) == 0),
               cv, 4'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
